core_inst_seq: RTL and testbench

CORE_INST_SEQ -- requirements
Module: core_inst_seq

---
 rtl/core_inst_seq.sv | 216 +++++++++++++++++++++
 tb/tb_core_inst_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_inst_seq.sv
// core_inst_seq
// Sequences one full convolution run on the core by emitting a 34-bit
// instruction word every cycle. For each kernel position (kij) it loads the
// weights from xmem into L0, shifts them into the PE array, lets them settle,
// loads the activations, executes, and drains the output FIFO into pmem.
// After the last kij it reads the partial sums back from pmem so that the
// core can accumulate them.
//
// Ports
//   clk         : single clock, rising edge
//   reset       : synchronous, active-high
//   start       : one-cycle pulse; begins a run when idle
//   ofifo_valid : output FIFO holds a full column set
//   inst[33:0]  : registered instruction word to the core
//   busy        : high whenever the sequencer is not idle
//   done        : one-cycle pulse when the run completes
module core_inst_seq #(
   parameter int          row      = 4,
   parameter int          col      = 8,
   parameter int          len_kij  = 9,
   parameter int          len_onij = 16,
   parameter logic [10:0] w_base   = 11'd0,
   parameter logic [10:0] a_base   = 11'd1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        ofifo_valid,
   output logic [33:0] inst,
   output logic        busy,
   output logic        done
);

   typedef enum logic [3:0] {
      IDLE, WLOAD, KLOAD, KWAIT, ALOAD, EXEC, DRAIN, ACC, DONE
   } state_t;

   // Both memories deselected and not writing, every other bit clear.
   localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

   localparam logic [10:0] COL_N     = 11'(col);
   localparam logic [10:0] COL_LAST  = 11'(col - 1);
   localparam logic [10:0] WAIT_LAST = 11'(row + col - 1);
   localparam logic [10:0] ONIJ_N    = 11'(len_onij);
   localparam logic [10:0] ONIJ_LAST = 11'(len_onij - 1);
   localparam logic [10:0] KIJ_LAST  = 11'(len_kij - 1);

   state_t      state;
   logic [10:0] cnt;
   logic [10:0] kij;
   logic [10:0] ocnt;
   logic        acc_pend;
   logic        acc_flush;

   // Shared WLOAD/ALOAD pattern: an xmem read on the first cycles and an L0
   // write of the previous read's data on every cycle but the first.
   function automatic logic [33:0] load_word(input logic rd, input logic [10:0] addr,
                                             input logic wr);
      logic [33:0] w;
      w = IDLE_WORD;
      if (rd) begin
         w[19]   = 1'b0;
         w[17:7] = addr;
      end
      w[2] = wr;
      return w;
   endfunction

   // pmem write of one drained FIFO column set, popping the FIFO together.
   function automatic logic [33:0] drain_word(input logic [10:0] addr);
      logic [33:0] w;
      w        = IDLE_WORD;
      w[32]    = 1'b0;
      w[31]    = 1'b0;
      w[30:20] = addr;
      w[6]     = 1'b1;
      return w;
   endfunction

   // pmem read of a partial sum; accum flags the data read one cycle earlier.
   function automatic logic [33:0] acc_word(input logic [10:0] addr, input logic acc);
      logic [33:0] w;
      w        = IDLE_WORD;
      w[32]    = 1'b0;
      w[30:20] = addr;
      w[33]    = acc;
      return w;
   endfunction

   // Single state machine; every output is decided from the current state and
   // counters and registered, so inst lags the state decision by one edge.
   // In ACC, cnt walks the kernel positions and ocnt the output pixels, and
   // one extra flush cycle issues the accum for the very last read.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         kij       <= '0;
         ocnt      <= '0;
         acc_pend  <= 1'b0;
         acc_flush <= 1'b0;
         inst      <= IDLE_WORD;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         inst <= IDLE_WORD;
         busy <= 1'b1;
         done <= 1'b0;
         case (state)
            IDLE: begin
               busy <= 1'b0;
               if (start) begin
                  state <= WLOAD;
                  cnt   <= '0;
                  kij   <= '0;
                  ocnt  <= '0;
               end
            end
            WLOAD: begin
               inst <= load_word(cnt < COL_N, w_base + kij * COL_N + cnt, cnt != '0);
               if (cnt == COL_N) begin
                  state <= KLOAD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 11'd1;
               end
            end
            KLOAD: begin
               inst <= IDLE_WORD | 34'h9;
               if (cnt == COL_LAST) begin
                  state <= KWAIT;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 11'd1;
               end
            end
            KWAIT: begin
               if (cnt == WAIT_LAST) begin
                  state <= ALOAD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 11'd1;
               end
            end
            ALOAD: begin
               inst <= load_word(cnt < ONIJ_N, a_base + cnt, cnt != '0);
               if (cnt == ONIJ_N) begin
                  state <= EXEC;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 11'd1;
               end
            end
            EXEC: begin
               inst <= IDLE_WORD | 34'hA;
               if (cnt == ONIJ_LAST) begin
                  state <= DRAIN;
                  cnt   <= '0;
                  ocnt  <= '0;
               end else begin
                  cnt <= cnt + 11'd1;
               end
            end
            DRAIN: begin
               if (ofifo_valid) begin
                  inst <= drain_word(kij * ONIJ_N + ocnt);
                  if (ocnt == ONIJ_LAST) begin
                     ocnt <= '0;
                     cnt  <= '0;
                     if (kij == KIJ_LAST) begin
                        state     <= ACC;
                        acc_pend  <= 1'b0;
                        acc_flush <= 1'b0;
                     end else begin
                        state <= WLOAD;
                        kij   <= kij + 11'd1;
                     end
                  end else begin
                     ocnt <= ocnt + 11'd1;
                  end
               end
            end
            ACC: begin
               if (!acc_flush) begin
                  inst     <= acc_word(cnt * ONIJ_N + ocnt, acc_pend);
                  acc_pend <= 1'b1;
                  if (cnt == KIJ_LAST) begin
                     cnt <= '0;
                     if (ocnt == ONIJ_LAST) begin
                        acc_flush <= 1'b1;
                     end else begin
                        ocnt <= ocnt + 11'd1;
                     end
                  end else begin
                     cnt <= cnt + 11'd1;
                  end
               end else begin
                  inst      <= IDLE_WORD | (34'h1 << 33);
                  acc_pend  <= 1'b0;
                  acc_flush <= 1'b0;
                  ocnt      <= '0;
                  state     <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_inst_seq.sv
// tb_core_inst_seq
// Self-checking bench for core_inst_seq with default parameters. A cycle
// table covers reset and the first weight/kernel load; hand sequences cover
// partial drains, reset mid-run and reset/start priority; full runs (directed
// and randomized) are compared against address lists and totals built from
// the run's loop structure.
module tb_core_inst_seq;

   localparam int ROW    = 4;
   localparam int COL    = 8;
   localparam int KIJ    = 9;
   localparam int ONIJ   = 16;
   localparam int W_BASE = 0;
   localparam int A_BASE = 1024;
   localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        ofifo_valid;
   logic [33:0] inst;
   logic        busy;
   logic        done;

   core_inst_seq dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .ofifo_valid(ofifo_valid),
      .inst(inst),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Observations gathered from inst every cycle
   int x_q[$];
   int pw_q[$];
   int pr_q[$];
   int acc_cnt, exec_cnt, kern_cnt, l0wr_cnt, done_cnt, rd_bad, lag_bad, cyc, done_cyc;
   bit prev_pread;

   typedef struct {
      logic        rst;
      logic        st;
      logic [33:0] exp_inst;
      logic        exp_busy;
      logic        exp_done;
   } vec_t;

   vec_t tbl[20];

   // Instruction words built straight from the field map
   function automatic logic [33:0] w_load(input bit rd, input int addr, input bit wr);
      logic [33:0] w;
      w = IDLE_W;
      if (rd) begin
         w[19]   = 1'b0;
         w[17:7] = addr[10:0];
      end
      w[2] = wr;
      return w;
   endfunction

   function automatic logic [33:0] w_kload();
      logic [33:0] w;
      w    = IDLE_W;
      w[3] = 1'b1;
      w[0] = 1'b1;
      return w;
   endfunction

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_output(input string name, input logic [33:0] act, input logic [33:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic clear_obs();
      x_q.delete();
      pw_q.delete();
      pr_q.delete();
      acc_cnt = 0; exec_cnt = 0; kern_cnt = 0; l0wr_cnt = 0; done_cnt = 0;
      rd_bad = 0; lag_bad = 0; cyc = 0; done_cyc = -1; prev_pread = 1'b0;
   endtask

   // One clock edge, then sample and classify the instruction word.
   task automatic tick();
      bit pw, pr;
      @(posedge clk);
      #1;
      cyc++;
      pw = (inst[32] == 1'b0) && (inst[31] == 1'b0);
      pr = (inst[32] == 1'b0) && (inst[31] == 1'b1);
      if (inst[19] == 1'b0) x_q.push_back(int'(inst[17:7]));
      if (pw) pw_q.push_back(int'(inst[30:20]));
      if (pr) pr_q.push_back(int'(inst[30:20]));
      if (inst[6] != pw) rd_bad++;
      if (inst[33]) acc_cnt++;
      if (inst[33] != prev_pread) lag_bad++;
      prev_pread = pr;
      if (inst[1]) exec_cnt++;
      if (inst[0]) kern_cnt++;
      if (inst[2]) l0wr_cnt++;
      if (done) begin
         done_cnt++;
         if (done_cyc < 0) done_cyc = cyc;
      end
   endtask

   task automatic apply_stimulus(input logic r, input logic s, input logic v);
      reset       = r;
      start       = s;
      ofifo_valid = v;
      tick();
   endtask

   task automatic wait_exec(input int target);
      int n;
      n = 0;
      while (exec_cnt < target && n < 2000) begin
         tick();
         n++;
      end
      check_int("exec_wait", exec_cnt, target);
   endtask

   task automatic begin_run();
      apply_stimulus(1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b1, 1'b0);
      start = 1'b0;
      clear_obs();
   endtask

   // Full run compared against lists derived from the loop nest of a run.
   task automatic run_full(input bit rnd);
      int exp_x[$];
      int exp_pw[$];
      int exp_pr[$];
      int bad, n;
      begin_run();
      n = 0;
      while (done_cnt == 0 && n < 5000) begin
         ofifo_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         start       = rnd ? ($urandom_range(0, 15) == 0) : 1'b0;
         tick();
         n++;
      end
      ofifo_valid = 1'b0;
      start       = 1'b0;
      tick();
      tick();
      for (int k = 0; k < KIJ; k++) begin
         for (int c = 0; c < COL; c++) exp_x.push_back((W_BASE + k * COL + c) % 2048);
         for (int o = 0; o < ONIJ; o++) exp_x.push_back((A_BASE + o) % 2048);
         for (int o = 0; o < ONIJ; o++) exp_pw.push_back((k * ONIJ + o) % 2048);
      end
      for (int o = 0; o < ONIJ; o++)
         for (int k = 0; k < KIJ; k++) exp_pr.push_back((k * ONIJ + o) % 2048);
      check_int("xmem_read_count", x_q.size(), exp_x.size());
      bad = 0;
      foreach (exp_x[i]) if (i >= x_q.size() || x_q[i] != exp_x[i]) bad++;
      check_int("xmem_addr_mismatches", bad, 0);
      check_int("pmem_write_count", pw_q.size(), exp_pw.size());
      bad = 0;
      foreach (exp_pw[i]) if (i >= pw_q.size() || pw_q[i] != exp_pw[i]) bad++;
      check_int("pmem_write_addr_mismatches", bad, 0);
      check_int("acc_read_count", pr_q.size(), exp_pr.size());
      bad = 0;
      foreach (exp_pr[i]) if (i >= pr_q.size() || pr_q[i] != exp_pr[i]) bad++;
      check_int("acc_read_addr_mismatches", bad, 0);
      check_int("accum_count", acc_cnt, KIJ * ONIJ);
      check_int("accum_lag_errors", lag_bad, 0);
      check_int("ofifo_rd_misaligned", rd_bad, 0);
      check_int("kernel_cycles", kern_cnt, KIJ * COL);
      check_int("exec_cycles", exec_cnt, KIJ * ONIJ);
      check_int("l0_wr_cycles", l0wr_cnt, KIJ * (COL + ONIJ));
      check_int("done_pulses", done_cnt, 1);
      check_int("busy_after_done", int'(busy), 0);
      if (!rnd)
         check_int("run_length", done_cyc,
                   KIJ * ((COL + 1) + COL + (ROW + COL) + (ONIJ + 1) + ONIJ + ONIJ)
                   + KIJ * ONIJ + 2);
   endtask

   initial begin
      reset       = 1'b1;
      start       = 1'b0;
      ofifo_valid = 1'b0;
      clear_obs();

      // Cycle table: reset, start, weight load, kernel load, first settle cycle
      for (int i = 0; i < 20; i++) begin
         tbl[i].rst      = 1'b0;
         tbl[i].st       = 1'b0;
         tbl[i].exp_inst = IDLE_W;
         tbl[i].exp_busy = 1'b1;
         tbl[i].exp_done = 1'b0;
      end
      tbl[0].rst      = 1'b1;
      tbl[0].exp_busy = 1'b0;
      tbl[1].st       = 1'b1;
      tbl[1].exp_busy = 1'b0;
      for (int i = 2; i <= 9; i++) tbl[i].exp_inst = w_load(1'b1, W_BASE + i - 2, i > 2);
      tbl[10].exp_inst = w_load(1'b0, 0, 1'b1);
      for (int i = 11; i <= 18; i++) tbl[i].exp_inst = w_kload();
      tbl[12].st = 1'b1;

      for (int i = 0; i < 20; i++) begin
         apply_stimulus(tbl[i].rst, tbl[i].st, 1'b0);
         check_output($sformatf("tbl%0d_inst", i), inst, tbl[i].exp_inst);
         check_int($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].exp_busy));
         check_int($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].exp_done));
      end

      // Drain of kij=2 with ofifo_valid 1,0,1, then a long stall
      begin_run();
      for (int k = 0; k < 3; k++) begin
         wait_exec(ONIJ * (k + 1));
         if (k < 2) begin
            for (int j = 0; j < ONIJ; j++) apply_stimulus(1'b0, 1'b0, 1'b1);
         end else begin
            apply_stimulus(1'b0, 1'b0, 1'b1);
            apply_stimulus(1'b0, 1'b0, 1'b0);
            apply_stimulus(1'b0, 1'b0, 1'b1);
         end
         ofifo_valid = 1'b0;
      end
      for (int j = 0; j < 20; j++) apply_stimulus(1'b0, 1'b0, 1'b0);
      check_int("drain_write_count", pw_q.size(), 2 * ONIJ + 2);
      if (pw_q.size() >= 2 * ONIJ + 2) begin
         check_int("drain_addr_a", pw_q[2 * ONIJ], 2 * ONIJ);
         check_int("drain_addr_b", pw_q[2 * ONIJ + 1], 2 * ONIJ + 1);
      end
      check_int("drain_ofifo_rd_misaligned", rd_bad, 0);
      check_int("drain_stall_busy", int'(busy), 1);
      check_output("drain_stall_inst", inst, IDLE_W);

      // Reset during EXEC, reset over start, then a clean restart
      begin_run();
      wait_exec(5);
      apply_stimulus(1'b1, 1'b1, 1'b0);
      check_output("reset_exec_inst", inst, IDLE_W);
      check_int("reset_exec_busy", int'(busy), 0);
      check_int("reset_exec_done", int'(done), 0);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_output("reset_beats_start", inst, IDLE_W);
      apply_stimulus(1'b0, 1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check_output("restart_first_read", inst, w_load(1'b1, W_BASE, 1'b0));
      check_int("restart_busy", int'(busy), 1);

      // Full runs: ofifo_valid held high, then random valid and stray starts
      run_full(1'b0);
      run_full(1'b1);
      run_full(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
